mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline MEM stage. Sits between the EX/MEM register and regs_memwb, and drives every mem_o_* input of regs_memwb.
- Performs load/store accesses to an external data memory over a req/ack handshake, with a bounded timeout.
- Generates byte enables, aligns and sign/zero-extends load data, and detects misaligned accesses.
- Stalls the pipeline while an access is in flight.

Parameters:
- TIMEOUT_CYC, 16, cycles in BUSY without dm_ack before the access is abandoned (>=2).

Ports:
- cpu_clk_50M in 1: clock
- cpu_rst_n in 1: reset; asynchronous, active-low
- mem_i_valid in 1: instruction present in MEM
- mem_i_memop in 4: 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; others treated as NONE
- mem_i_alures in 32: ALU result, or byte address for memops
- mem_i_rtdata in 32: store data
- mem_i_rfwe in 1, mem_i_rfwa in 5, mem_i_hilowe in 1, mem_i_mulres in 64: control/data passed through to WB
- dm_req out 1, dm_we out 1, dm_be out 4, dm_addr out 32 (word address {addr[31:2],2'b00}), dm_wdata out 32
- dm_ack in 1, dm_rdata in 32
- stall_req out 1: hold IF..EX and the EX/MEM register
- mem_o_dm2rf out 1, mem_o_hilowe out 1, mem_o_rfwe out 1, mem_o_bytesel out 4, mem_o_rfwa out 5, mem_o_mulres out 64, mem_o_alures out 32, mem_o_dmdout out 32
- mem_o_alignerr out 1: misaligned access flag
- mem_o_buserr out 1: timeout flag

Behaviour:
- Byte order and enables:
  - Little-endian byte lanes: addr[1:0]=n selects bits 8n+7:8n.
  - be: byte 0001<<addr[1:0]; half addr[1]?1100:0011; word 1111.
  - Store data is replicated into lanes: byte x4, half x2.
- Alignment:
  - Misaligned when half has addr[0]=1, or word has addr[1:0]!=0.
  - On a misaligned memop: no dm access, no stall, mem_o_alignerr=1, mem_o_rfwe=0, mem_o_dm2rf=0 in the same cycle.
- FSM states IDLE, BUSY, DONE; timeout counter is 5 bits.
  - IDLE: valid aligned memop -> stall_req=1 (combinational), next BUSY, counter cleared. Otherwise outputs are a combinational pass-through of mem_i_*.
  - BUSY:
    - dm_req=1; dm_we=1 for stores; dm_be/dm_addr/dm_wdata are registered at IDLE->BUSY and held stable until ack; stall_req=1.
    - dm_ack -> latch dm_rdata, next DONE.
    - Counter reaching TIMEOUT_CYC-1 without ack -> set buserr flag, next DONE.
  - DONE:
    - dm_req=0, stall_req=0.
    - Outputs present the completed instruction for exactly one cycle:
      - load: mem_o_dmdout = extended latched data, mem_o_dm2rf=1.
      - store: mem_o_rfwe=0, mem_o_dm2rf=0.
      - buserr: mem_o_buserr=1, mem_o_rfwe=0.
    - Next IDLE. Back-to-back memops therefore take 3 cycles each.
- dm_ack outside BUSY is ignored.
- While stall_req=1, all mem_o_* write enables (rfwe, hilowe, dm2rf) are forced to 0 so the bubble entering MEM/WB is harmless.
- mem_o_bytesel equals the access be for memops and 0000 otherwise.
- mem_o_alures, mem_o_rfwa and mem_o_mulres always pass through.
- Reset (async, any state, including mid-BUSY):
  - state IDLE, counter 0, latched data 0, dm_req 0.
  - All outputs: combinational outputs follow the IDLE rules, with reset treated as mem_i_valid=0 (enables 0, bytesel 0000, flags 0).
  - An in-flight ack arriving after reset is ignored.

Test Plan:
- ALU pass-through: valid, memop NONE, alures 0x1234_5678, rfwe=1, rfwa=5 -> same cycle mem_o_alures=0x12345678, rfwe=1, rfwa=5, stall_req=0, dm_req=0.
- LB sign extension: addr 0x103, dm_rdata 0x80FF_0000, ack on 2nd BUSY cycle -> dm_be=1000, dm_addr 0x100, stall for 3 cycles, DONE dmdout 0xFFFF_FF80, dm2rf=1; repeat with LBU -> 0x0000_0080.
- SH: addr 0x202, rtdata 0xABCD -> dm_we=1, dm_be=1100, dm_wdata 0xABCD_ABCD, DONE rfwe=0.
- Misaligned LW: addr 0x301 -> alignerr=1 same cycle, dm_req=0, stall_req=0, rfwe=0.
- Timeout: LW, dm_ack never asserted, TIMEOUT_CYC=4 -> dm_req high 4 cycles, DONE buserr=1, rfwe=0, then IDLE.
- Reset mid-BUSY: deassert cpu_rst_n between clocks -> dm_req and stall_req drop immediately; ack after reset release -> no output change.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : pipeline MEM stage - data-memory req/ack access with timeout
// Rev 1.0
// ============================================================================
module mem_stage #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic        mem_i_valid,
    input  logic [3:0]  mem_i_memop,
    input  logic [31:0] mem_i_alures,
    input  logic [31:0] mem_i_rtdata,
    input  logic        mem_i_rfwe,
    input  logic [4:0]  mem_i_rfwa,
    input  logic        mem_i_hilowe,
    input  logic [63:0] mem_i_mulres,
    output logic        dm_req,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall_req,
    output logic        mem_o_dm2rf,
    output logic        mem_o_hilowe,
    output logic        mem_o_rfwe,
    output logic [3:0]  mem_o_bytesel,
    output logic [4:0]  mem_o_rfwa,
    output logic [63:0] mem_o_mulres,
    output logic [31:0] mem_o_alures,
    output logic [31:0] mem_o_dmdout,
    output logic        mem_o_alignerr,
    output logic        mem_o_buserr
);

    localparam logic [3:0] c_OP_LB  = 4'd1;
    localparam logic [3:0] c_OP_LBU = 4'd2;
    localparam logic [3:0] c_OP_LH  = 4'd3;
    localparam logic [3:0] c_OP_LHU = 4'd4;
    localparam logic [3:0] c_OP_LW  = 4'd5;
    localparam logic [3:0] c_OP_SB  = 4'd6;
    localparam logic [3:0] c_OP_SH  = 4'd7;
    localparam logic [3:0] c_OP_SW  = 4'd8;
    localparam logic [4:0] c_CNT_LAST = 5'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_req;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_load;
    logic        r_sext;
    logic        r_size_b;
    logic        r_size_h;
    logic [1:0]  r_off;
    logic        r_rfwe;
    logic        r_hilowe;
    logic        r_buserr;

    logic        w_valid;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_size_b;
    logic        w_size_h;
    logic        w_size_w;
    logic        w_sext;
    logic        w_is_mem;
    logic [1:0]  w_off;
    logic        w_misalign;
    logic        w_start;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_lane_b;
    logic [15:0] w_lane_h;
    logic [31:0] w_ext;

    // Reset behaves as an empty slot so every enable and flag reads zero.
    assign w_valid    = mem_i_valid & cpu_rst_n;
    assign w_off      = mem_i_alures[1:0];
    assign w_is_mem   = w_valid & (w_is_load | w_is_store);
    assign w_misalign = (w_size_h & w_off[0]) | (w_size_w & (w_off != 2'b00));
    assign w_start    = (r_state == S_IDLE) & w_is_mem & ~w_misalign;

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_size_b   = 1'b0;
        w_size_h   = 1'b0;
        w_size_w   = 1'b0;
        w_sext     = 1'b0;
        case (mem_i_memop)
            c_OP_LB:  begin w_is_load  = 1'b1; w_size_b = 1'b1; w_sext = 1'b1; end
            c_OP_LBU: begin w_is_load  = 1'b1; w_size_b = 1'b1; end
            c_OP_LH:  begin w_is_load  = 1'b1; w_size_h = 1'b1; w_sext = 1'b1; end
            c_OP_LHU: begin w_is_load  = 1'b1; w_size_h = 1'b1; end
            c_OP_LW:  begin w_is_load  = 1'b1; w_size_w = 1'b1; end
            c_OP_SB:  begin w_is_store = 1'b1; w_size_b = 1'b1; end
            c_OP_SH:  begin w_is_store = 1'b1; w_size_h = 1'b1; end
            c_OP_SW:  begin w_is_store = 1'b1; w_size_w = 1'b1; end
            default:  ;
        endcase
    end

    // Store data is replicated across lanes so the memory only needs dm_be.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = mem_i_rtdata;
        if (w_size_b) begin
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{mem_i_rtdata[7:0]}};
        end else if (w_size_h) begin
            w_be    = w_off[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{mem_i_rtdata[15:0]}};
        end else if (w_size_w) begin
            w_be    = 4'b1111;
        end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_rdata  <= 32'd0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_be     <= 4'b0000;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_load   <= 1'b0;
            r_sext   <= 1'b0;
            r_size_b <= 1'b0;
            r_size_h <= 1'b0;
            r_off    <= 2'b00;
            r_rfwe   <= 1'b0;
            r_hilowe <= 1'b0;
            r_buserr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state  <= S_BUSY;
                        r_req    <= 1'b1;
                        r_cnt    <= 5'd0;
                        r_buserr <= 1'b0;
                        r_we     <= w_is_store;
                        r_be     <= w_be;
                        r_addr   <= {mem_i_alures[31:2], 2'b00};
                        r_wdata  <= w_wdata;
                        r_load   <= w_is_load;
                        r_sext   <= w_sext;
                        r_size_b <= w_size_b;
                        r_size_h <= w_size_h;
                        r_off    <= w_off;
                        r_rfwe   <= mem_i_rfwe;
                        r_hilowe <= mem_i_hilowe;
                    end
                end
                S_BUSY: begin
                    // A late ack in the final counted cycle still wins over the timeout.
                    if (dm_ack) begin
                        r_rdata <= dm_rdata;
                        r_req   <= 1'b0;
                        r_state <= S_DONE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_buserr <= 1'b1;
                        r_req    <= 1'b0;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_lane_b = r_rdata[7:0];
        case (r_off)
            2'd1:    w_lane_b = r_rdata[15:8];
            2'd2:    w_lane_b = r_rdata[23:16];
            2'd3:    w_lane_b = r_rdata[31:24];
            default: w_lane_b = r_rdata[7:0];
        endcase
        w_lane_h = r_off[1] ? r_rdata[31:16] : r_rdata[15:0];
        if (r_size_b) begin
            w_ext = {{24{r_sext & w_lane_b[7]}}, w_lane_b};
        end else if (r_size_h) begin
            w_ext = {{16{r_sext & w_lane_h[15]}}, w_lane_h};
        end else begin
            w_ext = r_rdata;
        end
    end

    assign dm_req   = r_req;
    assign dm_we    = r_req & r_we;
    assign dm_be    = r_be;
    assign dm_addr  = r_addr;
    assign dm_wdata = r_wdata;

    assign mem_o_alures = mem_i_alures;
    assign mem_o_rfwa   = mem_i_rfwa;
    assign mem_o_mulres = mem_i_mulres;

    always_comb begin
        stall_req      = 1'b0;
        mem_o_rfwe     = w_valid & mem_i_rfwe;
        mem_o_hilowe   = w_valid & mem_i_hilowe;
        mem_o_dm2rf    = 1'b0;
        mem_o_bytesel  = w_is_mem ? w_be : 4'b0000;
        mem_o_dmdout   = 32'd0;
        mem_o_alignerr = 1'b0;
        mem_o_buserr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_is_mem) begin
                    if (w_misalign) begin
                        mem_o_alignerr = 1'b1;
                        mem_o_rfwe     = 1'b0;
                    end else begin
                        stall_req = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                stall_req     = 1'b1;
                mem_o_bytesel = r_be;
            end
            S_DONE: begin
                mem_o_bytesel = r_be;
                mem_o_hilowe  = r_hilowe;
                mem_o_buserr  = r_buserr;
                mem_o_rfwe    = r_rfwe & r_load & ~r_buserr;
                mem_o_dm2rf   = r_load & ~r_buserr;
                mem_o_dmdout  = (r_load & ~r_buserr) ? w_ext : 32'd0;
            end
            default: ;
        endcase
        if (stall_req) begin
            mem_o_rfwe   = 1'b0;
            mem_o_hilowe = 1'b0;
            mem_o_dm2rf  = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_stage : randomized scoreboard bench with byte-level memory model
// Rev 1.0
// ============================================================================
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_i_valid;
    logic [3:0]  mem_i_memop;
    logic [31:0] mem_i_alures;
    logic [31:0] mem_i_rtdata;
    logic        mem_i_rfwe;
    logic [4:0]  mem_i_rfwa;
    logic        mem_i_hilowe;
    logic [63:0] mem_i_mulres;
    logic        dm_req, dm_we, dm_ack;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        stall_req;
    logic        mem_o_dm2rf, mem_o_hilowe, mem_o_rfwe, mem_o_alignerr, mem_o_buserr;
    logic [3:0]  mem_o_bytesel;
    logic [4:0]  mem_o_rfwa;
    logic [63:0] mem_o_mulres;
    logic [31:0] mem_o_alures, mem_o_dmdout;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYC(TO)) dut (
        .cpu_clk_50M(clk), .cpu_rst_n(rst_n),
        .mem_i_valid(mem_i_valid), .mem_i_memop(mem_i_memop), .mem_i_alures(mem_i_alures),
        .mem_i_rtdata(mem_i_rtdata), .mem_i_rfwe(mem_i_rfwe), .mem_i_rfwa(mem_i_rfwa),
        .mem_i_hilowe(mem_i_hilowe), .mem_i_mulres(mem_i_mulres),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall_req(stall_req),
        .mem_o_dm2rf(mem_o_dm2rf), .mem_o_hilowe(mem_o_hilowe), .mem_o_rfwe(mem_o_rfwe),
        .mem_o_bytesel(mem_o_bytesel), .mem_o_rfwa(mem_o_rfwa), .mem_o_mulres(mem_o_mulres),
        .mem_o_alures(mem_o_alures), .mem_o_dmdout(mem_o_dmdout),
        .mem_o_alignerr(mem_o_alignerr), .mem_o_buserr(mem_o_buserr)
    );

    typedef struct {
        logic [31:0] alures;
        logic [4:0]  rfwa;
        logic [63:0] mulres;
        logic        rfwe, hilowe, dm2rf, alignerr, buserr, chk_dout;
        logic [3:0]  bytesel;
        logic [31:0] dout;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        int          lat;
        int          exp_busy;
    } bus_t;

    exp_t        exp_q[$];
    bus_t        bus_q[$];
    bus_t        cur;
    logic [7:0]  ref_bytes[int];
    logic [31:0] dut_mem[int];
    int          errors = 0;
    int          checks = 0;
    int          resp_idx = 0;
    bit          resp_en = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic init_word(input int a, input logic [31:0] w);
        dut_mem[a >> 2] = w;
        for (int i = 0; i < 4; i++) ref_bytes[a + i] = w[8*i +: 8];
    endtask

    // External memory: acks after a per-request latency, spurious acks when idle.
    initial begin
        logic [31:0] word;
        int          k;
        dm_ack   = 1'b0;
        dm_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (!resp_en) continue;
            if (dm_req) begin
                if (resp_idx == 0) begin
                    if (bus_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL bus_unexpected: got request at %0h expected none", dm_addr);
                        cur = '{addr: 32'd0, be: 4'd0, we: 1'b0, wdata: 32'd0, lat: 99, exp_busy: -1};
                    end else begin
                        cur = bus_q.pop_front();
                        chk("dm_addr", dm_addr, cur.addr);
                        chk("dm_be", dm_be, cur.be);
                        chk("dm_we", dm_we, cur.we);
                        if (cur.we) chk("dm_wdata", dm_wdata, cur.wdata);
                    end
                end
                k    = int'(dm_addr[31:2]);
                word = dut_mem.exists(k) ? dut_mem[k] : 32'd0;
                dm_rdata = word;
                dm_ack   = (resp_idx == cur.lat);
                if (dm_ack && dm_we) begin
                    for (int l = 0; l < 4; l++)
                        if (dm_be[l]) word[8*l +: 8] = dm_wdata[8*l +: 8];
                    dut_mem[k] = word;
                end
                resp_idx++;
            end else begin
                if (resp_idx != 0) begin
                    if (cur.exp_busy >= 0) chk("busy_cycles", resp_idx, cur.exp_busy);
                    resp_idx = 0;
                end
                dm_ack   = ($urandom_range(0, 3) == 0);
                dm_rdata = $urandom;
            end
        end
    end

    // Monitor: an instruction completes on a cycle where it is valid and not stalled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && mem_i_valid) begin
                if (stall_req) begin
                    chk("stall_enables", {mem_o_rfwe, mem_o_hilowe, mem_o_dm2rf}, 3'b000);
                end else if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_empty: got completion expected none");
                end else begin
                    e = exp_q.pop_front();
                    chk("alures", mem_o_alures, e.alures);
                    chk("rfwa", mem_o_rfwa, e.rfwa);
                    chk("mulres", mem_o_mulres, e.mulres);
                    chk("rfwe", mem_o_rfwe, e.rfwe);
                    chk("hilowe", mem_o_hilowe, e.hilowe);
                    chk("dm2rf", mem_o_dm2rf, e.dm2rf);
                    chk("bytesel", mem_o_bytesel, e.bytesel);
                    chk("alignerr", mem_o_alignerr, e.alignerr);
                    chk("buserr", mem_o_buserr, e.buserr);
                    chk("done_req", dm_req, 1'b0);
                    if (e.chk_dout) chk("dmdout", mem_o_dmdout, e.dout);
                end
            end
        end
    end

    task automatic issue(input bit v, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] rt, input bit rfwe, input logic [4:0] rfwa,
                         input bit hilowe, input int lat);
        int          size, lo, base, n, exp_stall;
        bit          ld, st, sx, aligned, timed;
        logic [3:0]  be;
        logic [31:0] wd, val;
        exp_t        e;
        mem_i_valid  = v;
        mem_i_memop  = op;
        mem_i_alures = addr;
        mem_i_rtdata = rt;
        mem_i_rfwe   = rfwe;
        mem_i_rfwa   = rfwa;
        mem_i_hilowe = hilowe;
        mem_i_mulres = {$urandom, $urandom};
        size = 0; ld = 0; st = 0; sx = 0; timed = 0;
        if (v) begin
            case (op)
                4'd1: begin size = 1; ld = 1; sx = 1; end
                4'd2: begin size = 1; ld = 1; end
                4'd3: begin size = 2; ld = 1; sx = 1; end
                4'd4: begin size = 2; ld = 1; end
                4'd5: begin size = 4; ld = 1; end
                4'd6: begin size = 1; st = 1; end
                4'd7: begin size = 2; st = 1; end
                4'd8: begin size = 4; st = 1; end
                default: size = 0;
            endcase
        end
        lo      = int'(addr[1:0]);
        aligned = (size == 0) || ((lo % size) == 0);
        be = 4'b0000;
        wd = 32'd0;
        if (size > 0) begin
            base = lo - (lo % size);
            for (int i = 0; i < size; i++) be[base + i] = 1'b1;
            for (int l = 0; l < 4; l++) wd[8*l +: 8] = rt[8*(l % size) +: 8];
        end
        e = '{alures: addr, rfwa: rfwa, mulres: mem_i_mulres, rfwe: rfwe, hilowe: hilowe,
              dm2rf: 1'b0, alignerr: 1'b0, buserr: 1'b0, chk_dout: 1'b0, bytesel: be, dout: 32'd0};
        if (size > 0 && !aligned) begin
            e.alignerr = 1'b1;
            e.rfwe     = 1'b0;
        end else if (size > 0) begin
            timed = (lat >= TO);
            if (timed) begin
                e.buserr = 1'b1;
                e.rfwe   = 1'b0;
            end else if (st) begin
                e.rfwe = 1'b0;
                for (int i = 0; i < size; i++) ref_bytes[int'(addr) + i] = rt[8*i +: 8];
            end else begin
                val = 32'd0;
                for (int i = 0; i < size; i++) val[8*i +: 8] = ref_bytes[int'(addr) + i];
                if (sx && size < 4 && val[8*size - 1]) val = val | ~((32'd1 << (8*size)) - 32'd1);
                e.dm2rf    = 1'b1;
                e.chk_dout = 1'b1;
                e.dout     = val;
            end
            bus_q.push_back('{addr: {addr[31:2], 2'b00}, be: be, we: st, wdata: wd,
                              lat: lat, exp_busy: timed ? TO : lat + 1});
        end
        if (v) exp_q.push_back(e);
        exp_stall = (size > 0 && aligned) ? 1 + (timed ? TO : lat + 1) : 0;
        n = 0;
        forever begin
            @(negedge clk);
            if (!stall_req) break;
            n++;
            if (n > 20) begin
                checks++; errors++;
                $display("FAIL stall_bound: got stall beyond 20 cycles expected release");
                break;
            end
        end
        chk("stall_cycles", n, exp_stall);
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        mem_i_valid = 1'b1; mem_i_memop = 4'd5; mem_i_alures = 32'h0; mem_i_rtdata = 32'h0;
        mem_i_rfwe = 1'b1; mem_i_rfwa = 5'd3; mem_i_hilowe = 1'b1; mem_i_mulres = 64'h0;
        for (int a = 0; a < 64; a += 4) init_word(a, $urandom);
        init_word(32'h100, 32'h80FF_0000);
        init_word(32'h200, 32'h1111_2222);
        init_word(32'h300, 32'h3333_4444);

        #13;
        chk("rst_stall", stall_req, 1'b0);
        chk("rst_req", dm_req, 1'b0);
        chk("rst_enables", {mem_o_rfwe, mem_o_hilowe, mem_o_dm2rf}, 3'b000);
        chk("rst_bytesel", mem_o_bytesel, 4'b0000);
        chk("rst_flags", {mem_o_alignerr, mem_o_buserr}, 2'b00);
        @(posedge clk); #2;
        rst_n = 1'b1;

        issue(1, 4'd0, 32'h1234_5678, 32'h0, 1, 5'd5, 0, 0);
        issue(1, 4'd1, 32'h103, 32'h0, 1, 5'd7, 0, 1);
        issue(1, 4'd2, 32'h103, 32'h0, 1, 5'd7, 0, 1);
        issue(1, 4'd7, 32'h202, 32'h0000_ABCD, 1, 5'd8, 0, 0);
        issue(1, 4'd5, 32'h301, 32'h0, 1, 5'd9, 0, 0);
        issue(1, 4'd5, 32'h200, 32'h0, 1, 5'd10, 0, 7);
        issue(1, 4'd5, 32'h200, 32'h0, 1, 5'd11, 0, TO - 1);

        for (int t = 0; t < 150; t++)
            issue($urandom_range(0, 7) != 0, 4'($urandom_range(0, 11)), 32'($urandom_range(0, 63)),
                  $urandom, 1'($urandom), 5'($urandom), 1'($urandom), $urandom_range(0, 5));

        // Reset arriving mid-access: the request must vanish and a stale ack do nothing.
        mem_i_valid = 1'b1; mem_i_memop = 4'd5; mem_i_alures = 32'h10; mem_i_rfwe = 1'b1;
        bus_q.push_back('{addr: 32'h10, be: 4'hF, we: 1'b0, wdata: 32'd0, lat: 99, exp_busy: -1});
        @(posedge clk); #2;
        chk("busy_req", dm_req, 1'b1);
        chk("busy_stall", stall_req, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req", dm_req, 1'b0);
        chk("rst_mid_stall", stall_req, 1'b0);
        mem_i_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        resp_en = 1'b0;
        dm_ack = 1'b1;
        dm_rdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #2;
            dm_ack = 1'b0;
            chk("post_rst_req", dm_req, 1'b0);
            chk("post_rst_stall", stall_req, 1'b0);
            chk("post_rst_out", {mem_o_rfwe, mem_o_dm2rf, mem_o_buserr, mem_o_alignerr}, 4'b0000);
            chk("post_rst_dout", mem_o_dmdout, 32'd0);
        end
        issue(1, 4'd0, 32'hCAFE_0001, 32'h0, 1, 5'd2, 1, 0);

        chk("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
